// File: rtl/gpio_multiport.sv
// rtl/gpio_multiport.sv - memory-mapped multi-port GPIO with synchronised inputs and edge interrupts
module gpio_multiport #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 6,
    parameter int NUM_PORTS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cs,
    input  logic                             oe,
    input  logic                             we,
    input  logic [ADDR_WIDTH-1:0]            address,
    inout  wire  [DATA_WIDTH-1:0]            data,
    inout  wire  [NUM_PORTS*DATA_WIDTH-1:0]  pins,
    output logic                             irq
);

    localparam int W  = NUM_PORTS * DATA_WIDTH;
    localparam int PW = ADDR_WIDTH - 3;

    localparam logic [2:0] OFF_DDR    = 3'd0;
    localparam logic [2:0] OFF_PORT   = 3'd1;
    localparam logic [2:0] OFF_PIN    = 3'd2;
    localparam logic [2:0] OFF_TOGGLE = 3'd3;
    localparam logic [2:0] OFF_IE     = 3'd4;
    localparam logic [2:0] OFF_IFLAG  = 3'd5;
    localparam logic [2:0] OFF_EDGE   = 3'd6;

    logic [W-1:0]          ddr_q;
    logic [W-1:0]          port_q;
    logic [W-1:0]          ie_q;
    logic [W-1:0]          iflag_q;
    logic [W-1:0]          edge_q;
    logic [W-1:0]          prev_q;
    logic [W-1:0]          sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    logic [W-1:0]          pin_sync;
    logic [W-1:0]          rise;
    logic [W-1:0]          fall;
    logic [W-1:0]          edge_hit;
    logic [W-1:0]          wr_mask;
    logic [W-1:0]          wr_bits;
    logic [W-1:0]          clr_bits;
    logic [2:0]            wr_off;
    logic [PW-1:0]         wr_port;
    logic [2:0]            rd_off;
    logic [PW-1:0]         rd_port;
    logic [DATA_WIDTH-1:0] rd_data;

    assign wr_off   = address[2:0];
    assign wr_port  = address[ADDR_WIDTH-1:3];
    assign rd_off   = rd_addr_q[2:0];
    assign rd_port  = rd_addr_q[ADDR_WIDTH-1:3];

    // Lane mask of the written port; empty for out-of-range ports so such writes vanish
    always_comb begin
        wr_mask = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (cs && we && wr_port == PW'(p)) begin
                wr_mask[p*DATA_WIDTH +: DATA_WIDTH] = '1;
            end
        end
    end

    assign wr_bits  = {NUM_PORTS{data}} & wr_mask;
    assign clr_bits = (wr_off == OFF_IFLAG) ? wr_bits : '0;

    assign pin_sync = sync_q[SYNC_STAGES-1];
    assign rise     = pin_sync & ~prev_q;
    assign fall     = ~pin_sync & prev_q;
    assign edge_hit = ~ddr_q & ((edge_q & fall) | (~edge_q & rise));

    // Control registers and interrupt flags; a new edge beats a same-cycle W1C
    always_ff @(posedge clk) begin
        if (reset) begin
            ddr_q   <= '0;
            port_q  <= '0;
            ie_q    <= '0;
            iflag_q <= '0;
            edge_q  <= '0;
        end else begin
            case (wr_off)
                OFF_DDR:    ddr_q  <= (ddr_q  & ~wr_mask) | wr_bits;
                OFF_PORT:   port_q <= (port_q & ~wr_mask) | wr_bits;
                OFF_TOGGLE: port_q <= port_q ^ wr_bits;
                OFF_IE:     ie_q   <= (ie_q   & ~wr_mask) | wr_bits;
                OFF_EDGE:   edge_q <= (edge_q & ~wr_mask) | wr_bits;
                default:    ;
            endcase
            iflag_q <= (iflag_q & ~clr_bits) | edge_hit;
        end
    end

    // Pad synchroniser chain plus one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= pins;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= pin_sync;
        end
    end

    // Read address latch giving the one-clock read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q <= '0;
        end else if (cs && !we) begin
            rd_addr_q <= address;
        end
    end

    // Read mux from the latched address; nonexistent ports and WO/reserved offsets read 0
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_port == PW'(p)) begin
                case (rd_off)
                    OFF_DDR:   rd_data = ddr_q[p*DATA_WIDTH +: DATA_WIDTH];
                    OFF_PORT:  rd_data = port_q[p*DATA_WIDTH +: DATA_WIDTH];
                    OFF_PIN:   rd_data = pin_sync[p*DATA_WIDTH +: DATA_WIDTH];
                    OFF_IE:    rd_data = ie_q[p*DATA_WIDTH +: DATA_WIDTH];
                    OFF_IFLAG: rd_data = iflag_q[p*DATA_WIDTH +: DATA_WIDTH];
                    OFF_EDGE:  rd_data = edge_q[p*DATA_WIDTH +: DATA_WIDTH];
                    default:   rd_data = '0;
                endcase
            end
        end
    end

    assign data = (cs && oe && !we) ? rd_data : {DATA_WIDTH{1'bz}};

    for (genvar i = 0; i < W; i++) begin : g_pad
        assign pins[i] = ddr_q[i] ? port_q[i] : 1'bz;
    end

    assign irq = |(iflag_q & ie_q);

endmodule

// File: tb/tb_gpio_multiport.sv
// tb/tb_gpio_multiport.sv - scoreboard bench for gpio_multiport
module tb_gpio_multiport;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        oe;
    logic        we;
    logic [5:0]  address;
    logic [7:0]  dval;
    logic        den;
    logic [15:0] pval;
    logic [15:0] pen;
    logic        irq;
    wire  [7:0]  data;
    wire  [15:0] pins;

    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_q [$];

    gpio_multiport #(
        .DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_PORTS(2), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .cs(cs), .oe(oe), .we(we),
        .address(address), .data(data), .pins(pins), .irq(irq)
    );

    assign data = den ? dval : 8'bz;
    for (genvar i = 0; i < 16; i++) begin : g_drv
        assign pins[i] = pen[i] ? pval[i] : 1'bz;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1);
    end

    // Monitor: every cycle the DUT drives the bus, compare against the next expected read
    always @(negedge clk) begin
        if (cs && oe && !we) begin
            logic [7:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL read_unexpected: data=%h, required no bus drive", data);
            end else begin
                e = exp_q.pop_front();
                if (data !== e) begin
                    n_errors++;
                    $display("FAIL read addr_latched=%0d: got %h, required %h", address, data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        cs = 1; we = 1; oe = 0; address = a; dval = d; den = 1;
        @(posedge clk); #1;
        cs = 0; we = 0; den = 0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] e);
        @(posedge clk); #1;
        cs = 1; we = 0; oe = 0; address = a;
        exp_q.push_back(e);
        @(posedge clk); #1;
        oe = 1;
        @(posedge clk); #1;
        oe = 0; cs = 0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        reset = 1; cs = 0; oe = 0; we = 0; address = '0;
        dval = '0; den = 0; pval = '0; pen = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1 reset = 0;

        // Reset state
        for (int a = 0; a < 16; a++) rd(6'(a), 8'h00);
        check("irq_after_reset", {15'd0, irq}, 16'h0000);
        check("pins_after_reset", pins, 16'h0000);

        // Direction, output and toggle on port 0
        wr(6'd0, 8'hF0);
        pen[7:4] = 4'h0;
        wr(6'd1, 8'hA5);
        check("pins0_hi_after_port", {12'd0, pins[7:4]}, 16'h000A);
        check("pins0_lo_not_driven", {12'd0, pins[3:0]}, 16'h0000);
        wr(6'd3, 8'hFF);
        rd(6'd1, 8'h5A);
        rd(6'd3, 8'h00);
        rd(6'd0, 8'hF0);
        check("pins0_hi_after_toggle", {12'd0, pins[7:4]}, 16'h0005);

        // Input synchroniser latency on port 1
        @(posedge clk); #1;
        cs = 1; we = 0; oe = 0; address = 6'd10;
        @(posedge clk); #1;
        pval[15:8] = 8'h3C;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        oe = 1;
        repeat (4) @(posedge clk);
        #1 oe = 0; cs = 0;
        wr(6'd10, 8'hFF);
        rd(6'd10, 8'h3C);
        rd(6'd2, 8'h50);
        rd(6'd13, 8'h3C);
        wr(6'd13, 8'hFF);
        rd(6'd13, 8'h00);

        // Rising-edge interrupt on pin 8 with the documented latency
        wr(6'd12, 8'h01);
        wr(6'd14, 8'h00);
        @(posedge clk); #1;
        pval[8] = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("irq_before_edge3", {15'd0, irq}, 16'h0000);
        @(posedge clk);
        #1 check("irq_at_edge3", {15'd0, irq}, 16'h0001);
        rd(6'd13, 8'h01);
        wr(6'd13, 8'h01);
        rd(6'd13, 8'h00);
        check("irq_after_clear", {15'd0, irq}, 16'h0000);
        @(posedge clk); #1;
        pval[8] = 1'b0;
        repeat (5) @(posedge clk);
        rd(6'd13, 8'h00);
        check("irq_falling_ignored", {15'd0, irq}, 16'h0000);

        // Set and W1C on the same edge: set wins
        @(posedge clk); #1;
        pval[8] = 1'b1;
        repeat (2) @(posedge clk);
        #1 cs = 1; we = 1; address = 6'd13; dval = 8'h01; den = 1;
        @(posedge clk);
        #1 cs = 0; we = 0; den = 0;
        check("irq_set_beats_clear", {15'd0, irq}, 16'h0001);
        rd(6'd13, 8'h01);
        wr(6'd13, 8'h01);
        rd(6'd13, 8'h00);

        // Falling-edge select
        wr(6'd14, 8'h01);
        rd(6'd13, 8'h00);
        @(posedge clk); #1;
        pval[8] = 1'b0;
        repeat (5) @(posedge clk);
        rd(6'd13, 8'h01);
        check("irq_falling_selected", {15'd0, irq}, 16'h0001);

        // Nonexistent port index
        wr(6'd17, 8'hFF);
        wr(6'd21, 8'hFF);
        rd(6'd17, 8'h00);
        rd(6'd21, 8'h00);
        rd(6'd1, 8'h5A);
        rd(6'd8, 8'h00);
        rd(6'd13, 8'h01);

        // Reset in the middle of a read
        @(posedge clk); #1;
        cs = 1; we = 0; oe = 0; address = 6'd1;
        exp_q.push_back(8'h5A);
        @(posedge clk); #1;
        oe = 1;
        @(posedge clk); #1;
        reset = 1;
        exp_q.push_back(8'h5A);
        @(posedge clk); #1;
        exp_q.push_back(8'h00);
        pen[7:4] = 4'hF;
        pval[7:4] = 4'h0;
        check("irq_after_midreset", {15'd0, irq}, 16'h0000);
        check("pins_after_midreset", pins, 16'h3C00);
        @(posedge clk); #1;
        oe = 0; cs = 0; reset = 0;
        rd(6'd13, 8'h00);
        rd(6'd1, 8'h00);

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
